// File: rtl/object_ram_arbiter_if.sv
// Requester-side handshake bundles for the object RAM arbiter: a read-only
// renderer port and a read/write rope port with bus lock.
interface object_draw_if;
  logic        req;
  logic [3:0]  addr;
  logic        gnt;
  logic        valid;
  logic [31:0] data;

  modport master (output req, addr, input gnt, valid, data);
  modport slave  (input req, addr, output gnt, valid, data);
endinterface

interface object_rope_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        lock;
  logic        gnt;
  logic        valid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, lock, input gnt, valid, rdata);
  modport slave  (input req, we, addr, wdata, lock, output gnt, valid, rdata);
endinterface

// File: rtl/object_ram_arbiter.sv
// Arbitrates the single-port 16x32 object RAM between the renderer and up to two
// rope controllers; one transaction in flight, optional bus lock for atomic RMW.
module object_ram_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int LOCK_MAX     = 1024,
  parameter int NUM_ROPES    = 2
) (
  input  logic        clock,
  input  logic        resetn,
  object_draw_if.slave draw,
  object_rope_if.slave r0,
  object_rope_if.slave r1,
  output logic [3:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [1:0]  lock_owner,
  output logic        lock_timeout
);

  localparam int              LCW       = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCK_MAX - 1);
  localparam logic [1:0]      WAIT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [1:0]      OWN_NONE  = 2'b00;
  localparam logic [1:0]      OWN_R0    = 2'b01;
  localparam logic [1:0]      OWN_R1    = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic [1:0] {SRC_DRAW, SRC_R0, SRC_R1}   src_t;

  state_t         state;
  src_t           src;
  src_t           pick;
  logic           pick_ok;
  logic           cur_we;
  logic [1:0]     wait_cnt;
  logic           rr_ptr;
  logic [LCW-1:0] lock_cnt;
  logic [31:0]    draw_hold, r0_hold, r1_hold;
  logic           r1_req, r1_lock;
  logic           sel_we, sel_lock;
  logic [3:0]     sel_addr;
  logic [31:0]    sel_wdata;
  logic           fire;
  logic           owner_drop;

  // In single-player builds rope 1 is invisible to arbitration and locking.
  assign r1_req  = (NUM_ROPES > 1) && r1.req;
  assign r1_lock = (NUM_ROPES > 1) && r1.lock;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick    = SRC_DRAW;
    pick_ok = 1'b0;
    if (lock_owner == OWN_R0) begin
      pick    = SRC_R0;
      pick_ok = r0.req;
    end else if (lock_owner == OWN_R1) begin
      pick    = SRC_R1;
      pick_ok = r1_req;
    end else if (draw.req) begin
      pick    = SRC_DRAW;
      pick_ok = 1'b1;
    end else if (r0.req && r1_req) begin
      pick    = rr_ptr ? SRC_R1 : SRC_R0;
      pick_ok = 1'b1;
    end else if (r0.req) begin
      pick    = SRC_R0;
      pick_ok = 1'b1;
    end else if (r1_req) begin
      pick    = SRC_R1;
      pick_ok = 1'b1;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = draw.addr;
    sel_wdata = '0;
    case (pick)
      SRC_R0: begin
        sel_we = r0.we; sel_lock = r0.lock; sel_addr = r0.addr; sel_wdata = r0.wdata;
      end
      SRC_R1: begin
        sel_we = r1.we; sel_lock = r1_lock; sel_addr = r1.addr; sel_wdata = r1.wdata;
      end
      default: ;
    endcase
  end

  assign fire = ((state == ST_ISSUE) && !cur_we && (READ_LATENCY == 1)) ||
                ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));

  assign owner_drop = ((lock_owner == OWN_R0) && !r0.lock) ||
                      ((lock_owner == OWN_R1) && !r1_lock);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      src         <= SRC_DRAW;
      cur_we      <= 1'b0;
      wait_cnt    <= '0;
      rr_ptr      <= 1'b0;
      draw.gnt    <= 1'b0;
      r0.gnt      <= 1'b0;
      r1.gnt      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      draw.gnt <= 1'b0;
      r0.gnt   <= 1'b0;
      r1.gnt   <= 1'b0;
      ram_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_ok) begin
            state       <= ST_ISSUE;
            src         <= pick;
            cur_we      <= sel_we;
            ram_address <= sel_addr;
            ram_data    <= sel_wdata;
            ram_wren    <= sel_we;
            draw.gnt    <= (pick == SRC_DRAW);
            r0.gnt      <= (pick == SRC_R0);
            r1.gnt      <= (pick == SRC_R1);
            if (pick == SRC_R0)      rr_ptr <= 1'b1;
            else if (pick == SRC_R1) rr_ptr <= 1'b0;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= 2'd1;
          if (cur_we || (READ_LATENCY == 1)) state <= ST_IDLE;
          else                               state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= ST_IDLE;
          else                       wait_cnt <= wait_cnt + 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The lock counter runs for the whole time a lock is held, idle cycles included.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lock_owner   <= OWN_NONE;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      lock_timeout <= 1'b0;
      if (lock_owner != OWN_NONE) begin
        if (lock_cnt == LOCK_LAST) begin
          lock_owner   <= OWN_NONE;
          lock_cnt     <= '0;
          lock_timeout <= 1'b1;
        end else if (owner_drop) begin
          lock_owner <= OWN_NONE;
          lock_cnt   <= '0;
        end else begin
          lock_cnt <= lock_cnt + LCW'(1);
        end
      end else if ((state == ST_IDLE) && pick_ok && (pick != SRC_DRAW) && sel_lock) begin
        lock_owner <= (pick == SRC_R0) ? OWN_R0 : OWN_R1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      draw.valid <= 1'b0;
      r0.valid   <= 1'b0;
      r1.valid   <= 1'b0;
      draw_hold  <= '0;
      r0_hold    <= '0;
      r1_hold    <= '0;
    end else begin
      draw.valid <= fire && (src == SRC_DRAW);
      r0.valid   <= fire && (src == SRC_R0);
      r1.valid   <= fire && (src == SRC_R1);
      if (draw.valid) draw_hold <= ram_q;
      if (r0.valid)   r0_hold   <= ram_q;
      if (r1.valid)   r1_hold   <= ram_q;
    end
  end

  // Read data is ram_q during the valid cycle and the captured copy afterwards.
  assign draw.data = draw.valid ? ram_q : draw_hold;
  assign r0.rdata  = r0.valid   ? ram_q : r0_hold;
  assign r1.rdata  = r1.valid   ? ram_q : r1_hold;

endmodule
